// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: shared types and decode for the EX-stage ALU.
//   alu_op_e  - 4-bit internal operation codes
//   aluop_e   - 2-bit ALUOp from the main control unit
//   state_e   - execution unit control states
//   alu_decode() - total ALUOp/funct decode, returns {op, illegal}
package alu_exec_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_SLTU = 4'b1001,
    OP_MUL  = 4'b1010,
    OP_ILL  = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ITYPE = 2'b11
  } aluop_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

  typedef struct packed {
    alu_op_e op;
    logic    illegal;
  } dec_t;

  // funct3 values
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // full R-type funct = {funct7[0], funct7[5], funct3}
  localparam logic [4:0] FN_ADD  = 5'b00000;
  localparam logic [4:0] FN_SUB  = 5'b01000;
  localparam logic [4:0] FN_SLL  = 5'b00001;
  localparam logic [4:0] FN_SLT  = 5'b00010;
  localparam logic [4:0] FN_SLTU = 5'b00011;
  localparam logic [4:0] FN_XOR  = 5'b00100;
  localparam logic [4:0] FN_SRL  = 5'b00101;
  localparam logic [4:0] FN_SRA  = 5'b01101;
  localparam logic [4:0] FN_OR   = 5'b00110;
  localparam logic [4:0] FN_AND  = 5'b00111;
  localparam logic [4:0] FN_MUL  = 5'b10000;

  function automatic dec_t alu_decode(input aluop_e aluop, input logic [4:0] funct,
                                      input logic mul_en);
    dec_t       d;
    logic       f7_0;
    logic       f7_5;
    logic [2:0] f3;
    {f7_0, f7_5, f3} = funct;
    d.op = OP_ILL;
    case (aluop)
      ALUOP_ADD: d.op = OP_ADD;
      ALUOP_SUB: d.op = OP_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FN_ADD:  d.op = OP_ADD;
          FN_SUB:  d.op = OP_SUB;
          FN_SLL:  d.op = OP_SLL;
          FN_SLT:  d.op = OP_SLT;
          FN_SLTU: d.op = OP_SLTU;
          FN_XOR:  d.op = OP_XOR;
          FN_SRL:  d.op = OP_SRL;
          FN_SRA:  d.op = OP_SRA;
          FN_OR:   d.op = OP_OR;
          FN_AND:  d.op = OP_AND;
          FN_MUL:  d.op = mul_en ? OP_MUL : OP_ILL;
          default: d.op = OP_ILL;
        endcase
      end
      ALUOP_ITYPE: begin
        // immediate forms: f7 bits only matter for the shifts
        case (f3)
          F3_ADD:  d.op = OP_ADD;
          F3_SLT:  d.op = OP_SLT;
          F3_SLTU: d.op = OP_SLTU;
          F3_XOR:  d.op = OP_XOR;
          F3_OR:   d.op = OP_OR;
          F3_AND:  d.op = OP_AND;
          F3_SLL:  d.op = (!f7_0 && !f7_5) ? OP_SLL : OP_ILL;
          F3_SR:   d.op = f7_0 ? OP_ILL : (f7_5 ? OP_SRA : OP_SRL);
          default: d.op = OP_ILL;
        endcase
      end
      default: d.op = OP_ILL;
    endcase
    d.illegal = (d.op == OP_ILL);
    return d;
  endfunction

endpackage

// File: rtl/alu_exec_unit_mul.sv
// alu_iter_mul: iterative shift-add multiplier, one partial product per cycle.
//   start_i   - load operands, clear accumulator and counter
//   run_i     - perform one iteration this cycle
//   done_o    - current iteration is the last one
//   product_o - accumulator including this cycle's partial product (valid with done_o)
module alu_iter_mul #(
  parameter int XLEN  = 64,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            run_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] product_o
);

  logic [XLEN-1:0]  r_mcand;
  logic [XLEN-1:0]  r_mplier;
  logic [XLEN-1:0]  r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  w_acc_next;

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign done_o     = run_i && (r_cnt == CNT_W'(XLEN - 1));
  assign product_o  = w_acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (start_i) begin
      r_mcand  <= a_i;
      r_mplier <= b_i;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (run_i) begin
      r_acc    <= w_acc_next;
      r_mcand  <= {r_mcand[XLEN-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[XLEN-1:1]};
      r_cnt    <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage ALU with decode, single-cycle ops, iterative MUL and
// a registered valid/ready result.
//   flush_i                 - kill in-flight/held work, drop same-cycle input
//   in_valid_i/in_ready_o   - operand handshake (alu_op_i, funct_i, a_i, b_i)
//   out_valid_o/out_ready_i - result handshake (result_o, zero_o, op_o, illegal_o)
//   busy_o                  - multiplier iterating, used by the hazard unit to stall
//
// state   | meaning
// IDLE    | nothing held, ready for an operation
// MUL     | multiplier iterating, input stalled
// HOLD    | result valid, waiting for downstream
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter bit MUL_EN = 1'b1,
  parameter int CNT_W  = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [1:0]      alu_op_i,
  input  logic [4:0]      funct_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic [3:0]      op_o,
  output logic            illegal_o,
  output logic            busy_o
);

  localparam int SHW = $clog2(XLEN);

  state_e          r_state;
  state_e          w_state_nx;
  dec_t            w_dec;
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_alu;
  logic            w_accept;
  logic            w_is_mul;
  logic            w_mul_done;
  logic [XLEN-1:0] w_product;
  logic [XLEN-1:0] r_result;
  alu_op_e         r_op;
  logic            r_illegal;

  assign w_dec    = alu_decode(aluop_e'(alu_op_i), funct_i, MUL_EN);
  assign w_shamt  = b_i[SHW-1:0];
  assign w_is_mul = (w_dec.op == OP_MUL);
  assign w_accept = in_valid_i && in_ready_o;

  always_comb begin
    w_alu = '0;
    case (w_dec.op)
      OP_AND:  w_alu = a_i & b_i;
      OP_OR:   w_alu = a_i | b_i;
      OP_ADD:  w_alu = a_i + b_i;
      OP_XOR:  w_alu = a_i ^ b_i;
      OP_SLL:  w_alu = a_i << w_shamt;
      OP_SRL:  w_alu = a_i >> w_shamt;
      OP_SUB:  w_alu = a_i - b_i;
      OP_SRA:  w_alu = $unsigned($signed(a_i) >>> w_shamt);
      OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, (a_i < b_i)};
      default: w_alu = '0;
    endcase
  end

  alu_iter_mul #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (w_accept && w_is_mul),
    .run_i     (busy_o),
    .a_i       (a_i),
    .b_i       (b_i),
    .done_o    (w_mul_done),
    .product_o (w_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    if (flush_i) begin
      w_state_nx = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) w_state_nx = w_is_mul ? ST_MUL : ST_HOLD;
        ST_MUL:  if (w_mul_done) w_state_nx = ST_HOLD;
        ST_HOLD: begin
          if (out_ready_i) begin
            if (w_accept) w_state_nx = w_is_mul ? ST_MUL : ST_HOLD;
            else          w_state_nx = ST_IDLE;
          end
        end
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  // flush gates the handshakes combinationally so a killed result is never
  // retired and a same-cycle input is never taken
  always_comb begin
    in_ready_o  = !flush_i && ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && out_ready_i));
    out_valid_o = !flush_i && (r_state == ST_HOLD);
    busy_o      = !flush_i && (r_state == ST_MUL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result  <= '0;
      r_op      <= OP_AND;
      r_illegal <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      r_result  <= w_alu;
      r_op      <= w_dec.op;
      r_illegal <= w_dec.illegal;
    end else if (w_mul_done) begin
      r_result  <= w_product;
      r_op      <= OP_MUL;
      r_illegal <= 1'b0;
    end
  end

  assign result_o  = r_result;
  assign op_o      = r_op;
  assign illegal_o = r_illegal;
  assign zero_o    = (r_result == '0);

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [1:0]  alu_op_i;
  logic [4:0]  funct_i;
  logic [63:0] a_i;
  logic [63:0] b_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [63:0] result_o;
  logic        zero_o;
  logic [3:0]  op_o;
  logic        illegal_o;
  logic        busy_o;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(64), .MUL_EN(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .alu_op_i    (alu_op_i),
    .funct_i     (funct_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .zero_o      (zero_o),
    .op_o        (op_o),
    .illegal_o   (illegal_o),
    .busy_o      (busy_o)
  );

  typedef struct packed {
    logic [63:0] res;
    logic [3:0]  op;
    logic        ill;
  } exp_t;

  typedef struct packed {
    logic [1:0]  aop;
    logic [4:0]  fn;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic [3:0]  op;
    logic        ill;
  } vec_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_ret = 0;

  logic        s_oval, s_busy, s_iready, s_acc;
  logic [63:0] s_res;
  logic [3:0]  s_op;

  vec_t vecs [20] = '{
    '{2'b10, 5'b01101, 64'h8000_0000_0000_0000, 64'd4,  64'hF800_0000_0000_0000, 4'b0111, 1'b0},
    '{2'b11, 5'b01101, 64'h8000_0000_0000_0000, 64'd4,  64'hF800_0000_0000_0000, 4'b0111, 1'b0},
    '{2'b11, 5'b01001, 64'h8000_0000_0000_0000, 64'd4,  64'd0,                   4'b1111, 1'b1},
    '{2'b10, 5'b00111, 64'hF0F0,                64'hFF00, 64'hF000,              4'b0000, 1'b0},
    '{2'b10, 5'b00010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,  64'd1,                   4'b1000, 1'b0},
    '{2'b10, 5'b00011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,  64'd0,                   4'b1001, 1'b0},
    '{2'b10, 5'b00001, 64'd1,                   64'd67, 64'd8,                   4'b0100, 1'b0},
    '{2'b10, 5'b00101, 64'h8000_0000_0000_0000, 64'd63, 64'd1,                   4'b0101, 1'b0},
    '{2'b10, 5'b00100, 64'hFF00,                64'h0FF0, 64'hF0F0,              4'b0011, 1'b0},
    '{2'b10, 5'b00110, 64'hF000,                64'h000F, 64'hF00F,              4'b0001, 1'b0},
    '{2'b10, 5'b11000, 64'd1,                   64'd2,  64'd0,                   4'b1111, 1'b1},
    '{2'b10, 5'b10001, 64'd3,                   64'd3,  64'd0,                   4'b1111, 1'b1},
    '{2'b11, 5'b11000, 64'd20,                  64'd22, 64'd42,                  4'b0010, 1'b0},
    '{2'b11, 5'b10101, 64'h8000_0000_0000_0000, 64'd1,  64'd0,                   4'b1111, 1'b1},
    '{2'b11, 5'b00101, 64'h80,                  64'd3,  64'h10,                  4'b0101, 1'b0},
    '{2'b11, 5'b11111, 64'hF0F0,                64'h0FF0, 64'h00F0,              4'b0000, 1'b0},
    '{2'b11, 5'b00001, 64'd1,                   64'd63, 64'h8000_0000_0000_0000, 4'b0100, 1'b0},
    '{2'b11, 5'b01010, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5,  64'd1,                   4'b1000, 1'b0},
    '{2'b01, 5'b11111, 64'd3,                   64'd5,  64'hFFFF_FFFF_FFFF_FFFE, 4'b0110, 1'b0},
    '{2'b00, 5'b10000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,  64'd0,                   4'b0010, 1'b0}
  };

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // one cycle: sample at negedge, retire against the scoreboard, pass the posedge
  task automatic tick();
    exp_t e;
    @(negedge clk);
    s_oval   = out_valid_o;
    s_busy   = busy_o;
    s_iready = in_ready_o;
    s_acc    = in_valid_i && in_ready_o;
    s_res    = result_o;
    s_op     = op_o;
    if (out_valid_o && out_ready_i) begin
      n_vec++;
      assert (q.size() > 0) else begin
        n_err++;
        $error("FAIL spurious_result: observed result 0x%h with no pending vector, expected no output", result_o);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        check("result",  result_o,        e.res);
        check("op",      64'(op_o),       64'(e.op));
        check("illegal", 64'(illegal_o),  64'(e.ill));
        check("zero",    64'(zero_o),     64'(e.res == 64'd0));
        n_ret++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] aop, input logic [4:0] fn, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] er, input logic [3:0] eop,
                      input logic eill, input bit push, output int waits);
    exp_t e;
    alu_op_i   = aop;
    funct_i    = fn;
    a_i        = a;
    b_i        = b;
    in_valid_i = 1'b1;
    if (push) begin
      e.res = er;
      e.op  = eop;
      e.ill = eill;
      q.push_back(e);
    end
    waits = 0;
    do begin
      tick();
      waits++;
    end while (!s_acc && waits < 200);
    check("accept", 64'(s_acc), 64'd1);
    in_valid_i = 1'b0;
  endtask

  task automatic mul_wait(output int cycles, output int busy_cnt, output int rdy_cnt);
    cycles   = -1;
    busy_cnt = 0;
    rdy_cnt  = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (s_oval) begin
        cycles = i - 1;
        break;
      end
      if (s_busy)   busy_cnt++;
      if (s_iready) rdy_cnt++;
    end
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 200) begin
      tick();
      k++;
    end
    check("drain", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int w, cyc, bc, rc, ov, r0;
    rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    alu_op_i = 2'b00; funct_i = 5'b0; a_i = '0; b_i = '0;
    tick();
    tick();
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_result",    result_o,         64'd0);
    check("rst_op",        64'(op_o),        64'd0);
    check("rst_illegal",   64'(illegal_o),   64'd0);
    check("rst_busy",      64'(busy_o),      64'd0);
    check("rst_zero",      64'(zero_o),      64'd1);
    check("rst_in_ready",  64'(in_ready_o),  64'd1);
    rst_n = 1'b1;
    tick();

    // R-type SUB, one-cycle latency
    send(2'b10, 5'b01000, 64'd10, 64'd3, 64'd7, 4'b0110, 1'b0, 1'b1, w);
    check("sub_wait", 64'(w), 64'd1);
    tick();
    check("sub_latency", 64'(s_oval), 64'd1);

    // back-to-back ADD then SUB, funct ignored
    send(2'b00, 5'b01000, 64'd5, 64'd5, 64'd10, 4'b0010, 1'b0, 1'b1, w);
    check("b2b_wait0", 64'(w), 64'd1);
    send(2'b01, 5'b00111, 64'd9, 64'd9, 64'd0, 4'b0110, 1'b0, 1'b1, w);
    check("b2b_wait1", 64'(w), 64'd1);
    tick();
    check("b2b_ready", 64'(s_iready), 64'd1);
    check("b2b_retired", 64'(n_ret), 64'd3);

    // decode / datapath table at full throughput
    for (int i = 0; i < $size(vecs); i++) begin
      send(vecs[i].aop, vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].op,
           vecs[i].ill, 1'b1, w);
      check("tp_wait", 64'(w), 64'd1);
    end
    drain();

    // MUL from IDLE
    send(2'b10, 5'b10000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD,
         4'b1010, 1'b0, 1'b1, w);
    mul_wait(cyc, bc, rc);
    check("mul_latency", 64'(cyc), 64'd64);
    check("mul_busy_cycles", 64'(bc), 64'd64);
    check("mul_in_ready", 64'(rc), 64'd0);
    drain();

    // MUL accepted from HOLD while retiring an ADD
    send(2'b00, 5'b00000, 64'd2, 64'd2, 64'd4, 4'b0010, 1'b0, 1'b1, w);
    send(2'b10, 5'b10000, 64'd12345, 64'd6789, 64'd83810205, 4'b1010, 1'b0, 1'b1, w);
    check("mul_hold_wait", 64'(w), 64'd1);
    mul_wait(cyc, bc, rc);
    check("mul2_latency", 64'(cyc), 64'd64);
    drain();

    // backpressure on an AND result
    out_ready_i = 1'b0;
    send(2'b10, 5'b00111, 64'hFF, 64'h0F, 64'h0F, 4'b0000, 1'b0, 1'b1, w);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid",  64'(s_oval),   64'd1);
      check("bp_result", s_res,         64'h0F);
      check("bp_op",     64'(s_op),     64'd0);
      check("bp_ready",  64'(s_iready), 64'd0);
    end
    r0 = n_ret;
    out_ready_i = 1'b1;
    tick();
    check("bp_retire", 64'(n_ret - r0), 64'd1);
    tick();
    check("bp_once_valid", 64'(s_oval), 64'd0);
    check("bp_once_count", 64'(n_ret - r0), 64'd1);

    // flush in IDLE drops the presented input
    flush_i = 1'b1;
    alu_op_i = 2'b00; a_i = 64'd1; b_i = 64'd1; in_valid_i = 1'b1;
    tick();
    check("flush_idle_ready", 64'(s_iready), 64'd0);
    flush_i = 1'b0; in_valid_i = 1'b0;
    tick();
    check("flush_idle_drop", 64'(s_oval), 64'd0);

    // flush at MUL cycle 20
    send(2'b10, 5'b10000, 64'd7, 64'd9, 64'd0, 4'b0000, 1'b0, 1'b0, w);
    for (int i = 1; i < 20; i++) tick();
    check("flush_pre_busy", 64'(s_busy), 64'd1);
    flush_i = 1'b1;
    tick();
    check("flush_busy", 64'(s_busy), 64'd0);
    check("flush_valid", 64'(s_oval), 64'd0);
    flush_i = 1'b0;
    tick();
    check("flush_idle_busy", 64'(s_busy), 64'd0);
    check("flush_idle_rdy", 64'(s_iready), 64'd1);
    ov = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (s_oval) ov++;
    end
    check("flush_no_result", 64'(ov), 64'd0);

    // reset at MUL cycle 30
    send(2'b10, 5'b10000, 64'd7, 64'd9, 64'd0, 4'b0000, 1'b0, 1'b0, w);
    for (int i = 1; i < 30; i++) tick();
    check("rst_pre_busy", 64'(s_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rstm_busy",   64'(busy_o),      64'd0);
    check("rstm_valid",  64'(out_valid_o), 64'd0);
    check("rstm_result", result_o,         64'd0);
    check("rstm_zero",   64'(zero_o),      64'd1);
    tick();
    rst_n = 1'b1;
    ov = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (s_oval) ov++;
    end
    check("rstm_no_result", 64'(ov), 64'd0);
    check("scoreboard_empty", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
